gate_input_conditioner: RTL and testbench

GATE_INPUT_CONDITIONER -- requirements
Module: gate_input_conditioner

---
 rtl/parking_pkg.sv | 23 ++
 rtl/gate_input_conditioner_debouncer.sv | 64 ++++++
 rtl/gate_input_conditioner.sv | 186 ++++++++++++++++++
 tb/tb_gate_input_conditioner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate input conditioner: FSM state encoding,
// one-hot slot codes and the slot-validity helper.
package parking_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PULSE,
        RELEASE,
        LOCKOUT
    } gate_state_t;

    localparam logic [2:0] SLOT_NONE = 3'b000;
    localparam logic [2:0] SLOT1     = 3'b001;
    localparam logic [2:0] SLOT2     = 3'b010;
    localparam logic [2:0] SLOT3     = 3'b100;

    // Only the three one-hot codes select a slot; anything else is a rejected press.
    function automatic logic is_slot(input logic [2:0] sel);
        return (sel == SLOT1) || (sel == SLOT2) || (sel == SLOT3);
    endfunction

endpackage

// File: rtl/gate_input_conditioner_debouncer.sv
// One-bit debouncer: SYNC_STAGES-flop synchronizer followed by a saturating stability counter.
// o_stable_low flags a level that has been low for a full debounce window.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_stable_low
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_samp;
    logic                   r_level;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= i_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    // A new value counts as its own first sample; the count saturates at the window length.
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_sync != r_samp) begin
            w_cnt_next = CW'(1);
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_samp  <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_samp <= w_sync;
            r_cnt  <= w_cnt_next;
            if (w_cnt_next == CNT_MAX) begin
                r_level <= w_sync;
            end
        end
    end

    assign o_level      = r_level;
    assign o_stable_low = !r_level && !r_samp && (r_cnt == CNT_MAX);

endmodule

// File: rtl/gate_input_conditioner.sv
// Parking gate input conditioner: debounces entry/exit buttons, validates the slot switches and
// emits one-cycle car_enter/car_exit pulses. Define GATE_LOCKOUT_EN to add a post-release lockout.
module gate_input_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter,
    input  logic       btn_exit,
    input  logic [2:0] sw_sel,
    output logic       car_enter,
    output logic       car_exit,
    output logic [2:0] car_sel,
    output logic       sel_error
);

    gate_state_t r_state;
    gate_state_t w_state_next;

    logic [1:0] w_btn_raw;
    logic [1:0] w_btn_level;
    logic [1:0] w_btn_stable_low;
    logic [1:0] w_btn_rise;
    logic [1:0] r_btn_level_d;
    logic       r_armed;

    logic [2:0] r_sel_sync [SYNC_STAGES];
    logic [2:0] w_sel_sync;

    logic       r_dir_enter;
    logic       w_dir_enter_next;
    logic [2:0] r_car_sel;
    logic [2:0] w_car_sel_next;
    logic       r_sel_error;
    logic       w_sel_error_next;

    generate
        if (LOCKOUT_CYCLES < 1) begin : g_lockout_cycles_unsupported
        end
    endgenerate

    // Bit 0 is the entry button, bit 1 the exit button.
    assign w_btn_raw = {btn_exit, btn_enter};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .SYNC_STAGES    (SYNC_STAGES)
            ) u_debouncer (
                .clk         (clk),
                .reset       (reset),
                .i_raw       (w_btn_raw[gi]),
                .o_level     (w_btn_level[gi]),
                .o_stable_low(w_btn_stable_low[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sel_sync[i] <= SLOT_NONE;
            end
        end else begin
            r_sel_sync[0] <= sw_sel;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sel_sync[i] <= r_sel_sync[i-1];
            end
        end
    end

    assign w_sel_sync = r_sel_sync[SYNC_STAGES-1];

    // Rises stay masked after reset until both buttons have settled low, so a button held
    // through reset cannot fire when its debounced level first comes up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_level_d <= 2'b00;
            r_armed       <= 1'b0;
        end else begin
            r_btn_level_d <= w_btn_level;
            if (&w_btn_stable_low) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_btn_rise = w_btn_level & ~r_btn_level_d & {2{r_armed}};

`ifdef GATE_LOCKOUT_EN
    localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    logic [LW-1:0] r_lock_cnt;
    logic          w_lock_done;

    assign w_lock_done = (r_lock_cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_cnt <= '0;
        end else if (r_state == RELEASE && w_state_next == LOCKOUT) begin
            r_lock_cnt <= LW'(LOCKOUT_CYCLES - 1);
        end else if (r_state == LOCKOUT && !w_lock_done) begin
            r_lock_cnt <= r_lock_cnt - 1'b1;
        end
    end
`endif

    always_comb begin
        w_state_next     = r_state;
        w_dir_enter_next = r_dir_enter;
        w_car_sel_next   = r_car_sel;
        w_sel_error_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_btn_rise == 2'b11) begin
                    w_sel_error_next = 1'b1;
                    w_state_next     = RELEASE;
                end else if (w_btn_rise != 2'b00) begin
                    w_dir_enter_next = w_btn_rise[0];
                    w_state_next     = CHECK;
                end
            end
            CHECK: begin
                if (is_slot(w_sel_sync)) begin
                    w_car_sel_next = w_sel_sync;
                    w_state_next   = PULSE;
                end else begin
                    w_sel_error_next = 1'b1;
                    w_state_next     = RELEASE;
                end
            end
            PULSE: begin
                w_state_next = RELEASE;
            end
            RELEASE: begin
                if (w_btn_level == 2'b00) begin
`ifdef GATE_LOCKOUT_EN
                    w_state_next = LOCKOUT;
`else
                    w_state_next = IDLE;
`endif
                end
            end
            LOCKOUT: begin
`ifdef GATE_LOCKOUT_EN
                if (w_lock_done) begin
                    w_state_next = IDLE;
                end
`else
                w_state_next = IDLE;
`endif
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_dir_enter <= 1'b0;
            r_car_sel   <= SLOT_NONE;
            r_sel_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dir_enter <= w_dir_enter_next;
            r_car_sel   <= w_car_sel_next;
            r_sel_error <= w_sel_error_next;
        end
    end

    // Pulses decode straight from registered state, so they never overlap sel_error.
    assign car_enter = (r_state == PULSE) && r_dir_enter;
    assign car_exit  = (r_state == PULSE) && !r_dir_enter;
    assign car_sel   = r_car_sel;
    assign sel_error = r_sel_error;

endmodule

// File: tb/tb_gate_input_conditioner.sv
// Directed bench for gate_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2, LOCKOUT_CYCLES=8.
module tb_gate_input_conditioner;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LOCK = 8;
    localparam int NV   = 9;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       btn_enter = 1'b0;
    logic       btn_exit  = 1'b0;
    logic [2:0] sw_sel    = 3'b000;
    logic       car_enter;
    logic       car_exit;
    logic [2:0] car_sel;
    logic       sel_error;

    always #5 clk = ~clk;

    gate_input_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC),
        .LOCKOUT_CYCLES (LOCK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_enter(btn_enter),
        .btn_exit (btn_exit),
        .sw_sel   (sw_sel),
        .car_enter(car_enter),
        .car_exit (car_exit),
        .car_sel  (car_sel),
        .sel_error(sel_error)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_enter  = 0;
    int         n_exit   = 0;
    int         n_err    = 0;
    int         n_overlap = 0;
    logic [2:0] sel_at_pulse = 3'b000;

    // Output monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (car_enter) n_enter <= n_enter + 1;
        if (car_exit)  n_exit  <= n_exit + 1;
        if (sel_error) n_err   <= n_err + 1;
        if ((int'(car_enter) + int'(car_exit) + int'(sel_error)) > 1) n_overlap <= n_overlap + 1;
        if (car_enter || car_exit) sel_at_pulse <= car_sel;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       press_enter;
        logic       press_exit;
        logic       bounce;
        logic [2:0] sel;
        int         exp_enter;
        int         exp_exit;
        int         exp_err;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t vecs [NV];
    int   b_en, b_ex, b_er;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b1, 3'b010, 1, 0, 0, 3'b010}; // bouncing entry, slot 2
        vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b011, 0, 0, 1, 3'b010}; // exit with bad select
        vecs[2] = '{1'b1, 1'b1, 1'b0, 3'b001, 0, 0, 1, 3'b010}; // both buttons together
        vecs[3] = '{1'b0, 1'b1, 1'b0, 3'b100, 0, 1, 0, 3'b100};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b000, 0, 0, 1, 3'b100};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 3'b111, 0, 0, 1, 3'b100};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 3'b001, 0, 1, 0, 3'b001};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 3'b110, 0, 0, 1, 3'b001};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 3'b101, 0, 0, 1, 3'b001};

        // Reset state
        step(3);
        check("rst_car_enter", int'(car_enter), 0);
        check("rst_car_exit",  int'(car_exit),  0);
        check("rst_sel_error", int'(sel_error), 0);
        check("rst_car_sel",   int'(car_sel),   0);
        reset = 1'b1;
        step(10);

        for (int i = 0; i < NV; i++) begin
            b_en = n_enter; b_ex = n_exit; b_er = n_err;
            sw_sel = vecs[i].sel;
            if (vecs[i].bounce) begin
                btn_enter = vecs[i].press_enter; btn_exit = vecs[i].press_exit;
                step(1);
                btn_enter = 1'b0; btn_exit = 1'b0;
                step(1);
            end
            btn_enter = vecs[i].press_enter;
            btn_exit  = vecs[i].press_exit;
            step(20);
            btn_enter = 1'b0;
            btn_exit  = 1'b0;
            sw_sel    = ~vecs[i].sel;
            step(25);
            $display("vec %0d: enter=%0b exit=%0b sel=%03b -> car_enter x%0d car_exit x%0d sel_error x%0d car_sel=%03b",
                     i, vecs[i].press_enter, vecs[i].press_exit, vecs[i].sel,
                     n_enter - b_en, n_exit - b_ex, n_err - b_er, car_sel);
            check($sformatf("vec%0d_enter_pulses", i), n_enter - b_en, vecs[i].exp_enter);
            check($sformatf("vec%0d_exit_pulses", i),  n_exit - b_ex,  vecs[i].exp_exit);
            check($sformatf("vec%0d_error_pulses", i), n_err - b_er,   vecs[i].exp_err);
            check($sformatf("vec%0d_car_sel", i),      int'(car_sel),  int'(vecs[i].exp_sel));
            if ((vecs[i].exp_enter + vecs[i].exp_exit) > 0)
                check($sformatf("vec%0d_sel_at_pulse", i), int'(sel_at_pulse), int'(vecs[i].exp_sel));
        end

        // Latency: 2 sync + 4 debounce samples, then CHECK, then PULSE
        sw_sel = 3'b100;
        btn_enter = 1'b1;
        step(7);
        check("lat_before_pulse", int'(car_enter), 0);
        step(1);
        check("lat_pulse", int'(car_enter), 1);
        check("lat_car_sel", int'(car_sel), 4);
        step(1);
        check("lat_after_pulse", int'(car_enter), 0);
        step(15);
        btn_enter = 1'b0;
        step(25);
        $display("latency seq: car_sel=%03b", car_sel);

        // Select changes with no press have no effect
        b_en = n_enter; b_ex = n_exit; b_er = n_err;
        for (int k = 0; k < 16; k++) begin
            sw_sel = 3'(k);
            step(1);
        end
        check("idle_sel_car_sel", int'(car_sel), 4);
        check("idle_sel_events", (n_enter - b_en) + (n_exit - b_ex) + (n_err - b_er), 0);
        $display("idle select sweep: car_sel=%03b", car_sel);

        // Reset during CHECK, button held through reset
        sw_sel = 3'b010;
        btn_enter = 1'b1;
        step(7);
        reset = 1'b0;
        #1;
        check("midrst_car_enter", int'(car_enter), 0);
        check("midrst_car_exit",  int'(car_exit),  0);
        check("midrst_sel_error", int'(sel_error), 0);
        check("midrst_car_sel",   int'(car_sel),   0);
        b_en = n_enter;
        step(3);
        reset = 1'b1;
        step(30);
        check("held_after_rst_no_pulse", n_enter - b_en, 0);
        btn_enter = 1'b0;
        step(15);
        btn_enter = 1'b1;
        step(20);
        btn_enter = 1'b0;
        step(25);
        check("repress_after_rst_pulse", n_enter - b_en, 1);
        check("repress_after_rst_car_sel", int'(car_sel), 2);
        $display("reset-in-check seq: enter pulses after re-press %0d, car_sel=%03b", n_enter - b_en, car_sel);

        // Exit press 3 cycles after an accepted entry is released
        b_en = n_enter; b_ex = n_exit;
        sw_sel = 3'b010;
        btn_enter = 1'b1;
        step(20);
        btn_enter = 1'b0;
        step(3);
        sw_sel = 3'b001;
        btn_exit = 1'b1;
        step(10);
        btn_exit = 1'b0;
        step(25);
        check("quick_second_enter", n_enter - b_en, 1);
`ifdef GATE_LOCKOUT_EN
        check("quick_second_exit_ignored", n_exit - b_ex, 0);
        check("quick_second_car_sel", int'(car_sel), 2);
`else
        check("quick_second_exit_taken", n_exit - b_ex, 1);
        check("quick_second_car_sel", int'(car_sel), 1);
`endif
        $display("quick second press: enter x%0d exit x%0d car_sel=%03b", n_enter - b_en, n_exit - b_ex, car_sel);

        // Press 12 cycles after release is accepted in either build
        b_en = n_enter;
        sw_sel = 3'b100;
        btn_enter = 1'b1;
        step(20);
        btn_enter = 1'b0;
        step(12);
        btn_enter = 1'b1;
        step(20);
        btn_enter = 1'b0;
        step(25);
        check("late_second_enter", n_enter - b_en, 2);
        check("late_second_car_sel", int'(car_sel), 4);
        $display("late second press: enter x%0d car_sel=%03b", n_enter - b_en, car_sel);

        check("no_output_overlap", n_overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
